// File: rtl/db_qp_line_buf.sv
// Two-port per-column QP line buffer: lane-masked writes, 1-cycle registered read, clear sweep on reset/clr_i.
// No backpressure; ports are ignored while clr_busy_o is high. Optional forwarding via DB_QP_LINE_BUF_FWD_EN.
`ifndef PIC_X_WIDTH
`define PIC_X_WIDTH 8
`endif

module db_qp_line_buf #(
    parameter int                    Word_Width = 20,
    parameter int                    Addr_Width = `PIC_X_WIDTH,
    parameter int                    Lane_Width = 2,
    parameter int                    Lane_Num   = Word_Width / Lane_Width,
    parameter logic [Word_Width-1:0] Clr_Value  = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr_i,
    output logic                  clr_busy_o,
    input  logic                  ren_i,
    input  logic [Addr_Width-1:0] raddr_i,
    output logic [Word_Width-1:0] rdata_o,
    output logic                  rvalid_o,
    input  logic                  wen_i,
    input  logic [Addr_Width-1:0] waddr_i,
    input  logic [Word_Width-1:0] wdata_i,
    input  logic [Lane_Num-1:0]   bwen_i
);

    localparam int Depth = 1 << Addr_Width;

    typedef enum logic {CLR, IDLE} state_t;

    state_t                state_q, state_d;
    logic [Addr_Width-1:0] clr_ptr_q, clr_ptr_d;
    logic                  clr_busy_q;
    logic                  rvalid_q;
    logic [Word_Width-1:0] rdata_q, rdata_d;

    logic [Word_Width-1:0] mem [Depth];

    logic                  mem_we;
    logic [Addr_Width-1:0] mem_waddr;
    logic [Word_Width-1:0] mem_wdata;
    logic [Lane_Num-1:0]   mem_wmask;
    logic                  port_ren;
    logic                  port_wen;
    logic [Word_Width-1:0] rd_word;

    // The sweep owns the write port; a clr_i in IDLE wins over a same-cycle write.
    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        mem_we    = 1'b0;
        mem_waddr = waddr_i;
        mem_wdata = wdata_i;
        mem_wmask = bwen_i;
        port_ren  = 1'b0;
        port_wen  = 1'b0;
        case (state_q)
            CLR: begin
                mem_we    = 1'b1;
                mem_waddr = clr_ptr_q;
                mem_wdata = Clr_Value;
                mem_wmask = '1;
                if (clr_i) begin
                    clr_ptr_d = '0;
                end else begin
                    clr_ptr_d = clr_ptr_q + 1'b1;
                    if (clr_ptr_q == '1) begin
                        state_d = IDLE;
                    end
                end
            end
            IDLE: begin
                port_ren = ren_i;
                if (clr_i) begin
                    state_d   = CLR;
                    clr_ptr_d = '0;
                end else begin
                    port_wen = wen_i;
                    mem_we   = wen_i;
                end
            end
            default: state_d = CLR;
        endcase
    end

    always_comb begin
        rd_word = mem[raddr_i];
`ifdef DB_QP_LINE_BUF_FWD_EN
        if (port_wen && (waddr_i == raddr_i)) begin
            for (int k = 0; k < Lane_Num; k++) begin
                if (bwen_i[k]) begin
                    rd_word[k*Lane_Width +: Lane_Width] = wdata_i[k*Lane_Width +: Lane_Width];
                end
            end
        end
`endif
        rdata_d = port_ren ? rd_word : rdata_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= CLR;
            clr_ptr_q  <= '0;
            clr_busy_q <= 1'b1;
            rdata_q    <= '0;
            rvalid_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_ptr_q  <= clr_ptr_d;
            clr_busy_q <= (state_d == CLR);
            rdata_q    <= rdata_d;
            rvalid_q   <= port_ren;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int k = 0; k < Lane_Num; k++) begin
                if (mem_wmask[k]) begin
                    mem[mem_waddr][k*Lane_Width +: Lane_Width] <= mem_wdata[k*Lane_Width +: Lane_Width];
                end
            end
        end
    end

    assign clr_busy_o = clr_busy_q;
    assign rdata_o    = rdata_q;
    assign rvalid_o   = rvalid_q;

endmodule

// File: tb/tb_db_qp_line_buf.sv
// Directed bench for db_qp_line_buf at Addr_Width=4 with hand-computed expected values.
module tb_db_qp_line_buf;

    localparam int AW = 4;
    localparam int WW = 20;
    localparam int LN = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          clr_i;
    logic          clr_busy_o;
    logic          ren_i;
    logic [AW-1:0] raddr_i;
    logic [WW-1:0] rdata_o;
    logic          rvalid_o;
    logic          wen_i;
    logic [AW-1:0] waddr_i;
    logic [WW-1:0] wdata_i;
    logic [LN-1:0] bwen_i;

    int errors = 0;
    int checks = 0;

    db_qp_line_buf #(
        .Word_Width (WW),
        .Addr_Width (AW),
        .Lane_Width (2),
        .Clr_Value  ('0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (clr_i),
        .clr_busy_o (clr_busy_o),
        .ren_i      (ren_i),
        .raddr_i    (raddr_i),
        .rdata_o    (rdata_o),
        .rvalid_o   (rvalid_o),
        .wen_i      (wen_i),
        .waddr_i    (waddr_i),
        .wdata_i    (wdata_i),
        .bwen_i     (bwen_i)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [WW-1:0] d, input logic [LN-1:0] m);
        wen_i   = 1'b1;
        waddr_i = a;
        wdata_i = d;
        bwen_i  = m;
        step();
        wen_i   = 1'b0;
        bwen_i  = '0;
    endtask

    task automatic rd(input string tag, input logic [AW-1:0] a, input logic [WW-1:0] e);
        ren_i   = 1'b1;
        raddr_i = a;
        step();
        ren_i   = 1'b0;
        chk({tag, "_vld"}, {31'd0, rvalid_o}, 32'd1);
        chk(tag, {12'd0, rdata_o}, {12'd0, e});
    endtask

    task automatic busy_len(input string tag);
        int cnt = 0;
        while (clr_busy_o === 1'b1 && cnt < 100) begin
            cnt++;
            step();
        end
        chk(tag, cnt, 32'd16);
    endtask

    initial begin
        rst = 1'b1; clr_i = 1'b0; ren_i = 1'b0; raddr_i = '0;
        wen_i = 1'b0; waddr_i = '0; wdata_i = '0; bwen_i = '0;
        step();
        step();
        chk("rst_busy",   {31'd0, clr_busy_o}, 32'd1);
        chk("rst_rdata",  {12'd0, rdata_o},    32'd0);
        chk("rst_rvalid", {31'd0, rvalid_o},   32'd0);

        rst = 1'b0;
        busy_len("init_sweep_len");
        for (int i = 0; i < 16; i++) rd("init_rd", AW'(i), 20'h0);
        step();
        chk("idle_rvalid_low", {31'd0, rvalid_o}, 32'd0);

        // Masked write: lanes 0..2 (bits 5:0) cleared.
        wr(4'd3, 20'hFFFFF, 10'h3FF);
        wr(4'd3, 20'h00000, 10'b0000000111);
        rd("masked_wr", 4'd3, 20'hFFFC0);
        wr(4'd4, 20'hFFFFF, 10'h000);
        rd("zero_mask_wr", 4'd4, 20'h0);
        wr(4'd6, 20'hABCDE, 10'b1111100000);
        rd("upper_lanes_wr", 4'd6, 20'hABC00);

        // Collision on addr 5 (previous content 0).
        ren_i = 1'b1; raddr_i = 4'd5;
        wen_i = 1'b1; waddr_i = 4'd5; wdata_i = 20'h12345; bwen_i = '1;
        step();
        ren_i = 1'b0; wen_i = 1'b0; bwen_i = '0;
`ifdef DB_QP_LINE_BUF_FWD_EN
        chk("collision_rd", {12'd0, rdata_o}, 32'h12345);
`else
        chk("collision_rd", {12'd0, rdata_o}, 32'h0);
`endif
        rd("collision_reread", 4'd5, 20'h12345);

        // Clear on request.
        for (int i = 0; i < 16; i++) wr(AW'(i), 20'hABCDE, 10'h3FF);
        rd("fill_rd", 4'd7, 20'hABCDE);
        clr_i = 1'b1;
        step();
        clr_i = 1'b0;
        chk("clr_busy_rise", {31'd0, clr_busy_o}, 32'd1);
        for (int i = 0; i < 4; i++) step();
        ren_i = 1'b1; raddr_i = 4'd2;
        wen_i = 1'b1; waddr_i = 4'd2; wdata_i = 20'h12345; bwen_i = '1;
        step();
        ren_i = 1'b0; wen_i = 1'b0; bwen_i = '0;
        chk("busy_rvalid", {31'd0, rvalid_o}, 32'd0);
        chk("busy_rdata_hold", {12'd0, rdata_o}, 32'hABCDE);
        begin
            int guard = 0;
            while (clr_busy_o === 1'b1 && guard < 100) begin
                guard++;
                step();
            end
            chk("clr_done", {31'd0, clr_busy_o}, 32'd0);
        end
        for (int i = 0; i < 16; i++) rd("clr_rd", AW'(i), 20'h0);

        // Restart of a sweep already in progress.
        clr_i = 1'b1;
        step();
        clr_i = 1'b0;
        for (int i = 0; i < 8; i++) step();
        clr_i = 1'b1;
        step();
        clr_i = 1'b0;
        busy_len("restart_sweep_len");

        // Reset in the middle of a sweep.
        wr(4'd9, 20'h55555, 10'h3FF);
        rd("pre_rst_rd", 4'd9, 20'h55555);
        clr_i = 1'b1;
        step();
        clr_i = 1'b0;
        for (int i = 0; i < 5; i++) step();
        rst = 1'b1;
        #1;
        chk("midrst_rdata", {12'd0, rdata_o}, 32'h0);
        step();
        chk("midrst_busy", {31'd0, clr_busy_o}, 32'd1);
        rst = 1'b0;
        busy_len("midrst_sweep_len");
        chk("post_rst_rdata", {12'd0, rdata_o}, 32'h0);
        rd("post_rst_rd", 4'd9, 20'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/db_qp_line_buf.md
# db_qp_line_buf

Parametrised two-port QP line buffer for the deblocking filter, holding per-column QP words: qp_top in [5:0], qp_top_modified in [11:6] and qp_top_flag in [19:12] at default width. It adds four things to the single-port QP RAM model: separate read and write ports, per-lane write masking, a hardware clear sweep after reset or on request, and optional write-to-read forwarding. It sits between the deblocking controller and the filter datapath and is reused for any per-column side-info line.

## Interface
Parameters:
- Word_Width, 20, word width in bits.
- Addr_Width, `PIC_X_WIDTH, address width; depth is 1<<Addr_Width.
- Lane_Width, 2, bits per mask lane. Word_Width must be a multiple of Lane_Width.
- Lane_Num, Word_Width/Lane_Width, number of mask lanes (derived).
- Clr_Value, 0, value written to every entry by the clear sweep.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- clr_i  in  1  request a clear sweep, single-cycle pulse.
- clr_busy_o  out  1  clear sweep in progress.
- ren_i  in  1  read enable, active-high.
- raddr_i  in  Addr_Width  read address.
- rdata_o  out  Word_Width  registered read data.
- rvalid_o  out  1  rdata_o updated this cycle.
- wen_i  in  1  write enable, active-high.
- waddr_i  in  Addr_Width  write address.
- wdata_i  in  Word_Width  write data.
- bwen_i  in  Lane_Num  per-lane write enable, active-high. Lane k covers bits [k*Lane_Width +: Lane_Width].

## Operation
- FSM states: CLR, IDLE.
- Reset puts the FSM in CLR with clr_ptr=0.
  - Memory has no reset; the CLR state is how the array is initialised.
- CLR state:
  - Each cycle writes Clr_Value to mem[clr_ptr], then increments clr_ptr.
  - After writing address (1<<Addr_Width)-1, clr_ptr wraps to 0 and the FSM goes to IDLE.
- IDLE state:
  - clr_i=1 moves to CLR with clr_ptr=0.
- clr_i while in CLR restarts the sweep at address 0.
- While in CLR, ren_i and wen_i are ignored:
  - no memory write from the ports;
  - rdata_o holds its value;
  - rvalid_o=0.
- Write (IDLE, wen_i=1):
  - For each lane k with bwen_i[k]=1, the lane's bits of mem[waddr_i] take the lane's bits of wdata_i.
  - Lanes with bwen_i[k]=0 keep their value.
  - bwen_i=0 writes nothing.
- Read (IDLE, ren_i=1):
  - rdata_o takes mem[raddr_i] at the next edge, and rvalid_o=1 for that one cycle.
  - With ren_i=0, rdata_o holds and rvalid_o=0.
- Same-cycle read and write to the same address: see Configuration.
- clr_i and wen_i in the same IDLE cycle: the write is dropped and the clear starts.

## Timing
- Reset values:
  - clr_busy_o=1;
  - rdata_o=0;
  - rvalid_o=0;
  - FSM=CLR, clr_ptr=0.
- clr_busy_o is a registered copy of (FSM==CLR).
  - After rst falls it stays high for exactly 1<<Addr_Width cycles.
  - It goes high the cycle after an accepted clr_i.
- Read latency is 1 cycle, and there are no wait states in IDLE.
- rst asserted mid-sweep or mid-access aborts it. After release, the full sweep restarts at address 0.

## Configuration
- Macro DB_QP_LINE_BUF_FWD_EN.
- Defined:
  - A read and a write to the same address in the same IDLE cycle return the merged word: written lanes come from wdata_i, unwritten lanes from the old mem contents.
  - This costs one comparator and a lane mux in front of the read register.
- Undefined:
  - The same collision returns the old mem contents (read-before-write).
  - The write still commits.

## Test plan
- Reset sweep (Addr_Width=4, Clr_Value=0): release rst.
  - clr_busy_o must be 1 for 16 cycles, then 0.
  - Reading addresses 0..15 must then return 0, each with rvalid_o one cycle after ren_i.
- Masked write:
  - First write addr 3, data 20'hFFFFF, bwen_i all ones.
  - Then write addr 3, data 0, bwen_i=10'b0000000111.
  - Reading addr 3 must return 20'hFFFC0.
- Collision: write addr 5 with 20'h12345 (all lanes) while reading addr 5; previous content is 0.
  - With FWD_EN, rdata_o=20'h12345.
  - Without FWD_EN, rdata_o=0. A re-read returns 20'h12345.
- Clear on request:
  - Fill all entries with 20'hABCDE, pulse clr_i, then during busy issue a write to addr 2 and a read.
  - The write must be ignored and rvalid_o=0.
  - After busy drops, every entry must read 0.
- clr_i restart: pulse clr_i again at sweep cycle 8. clr_busy_o must stay high for 16 further cycles.
- Reset mid-sweep: assert rst at sweep cycle 5. After release, clr_busy_o must be high for 16 cycles and rdata_o=0.
